// File: rtl/anim_pkg.sv
// Shared defaults and state type for the sprite animation scheduler.
// SPRITE_ANIM_LOOP_EN enables per-request looping; without it every sequence is one-shot.
package anim_pkg;

  localparam int DEF_NUM_CH  = 4;
  localparam int DEF_FRAME_W = 4;
  localparam int DEF_HOLD_W  = 6;

  typedef enum logic {
    ANIM_IDLE = 1'b0,
    ANIM_RUN  = 1'b1
  } anim_state_t;

`ifdef SPRITE_ANIM_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

endpackage

// File: rtl/anim_channel.sv
// One animation channel: captures a request on load and steps frames on frame ticks.
// Looping honoured only when SPRITE_ANIM_LOOP_EN is defined (see anim_pkg::LOOP_EN).
//
// state     | meaning
// ANIM_IDLE | no sequence active, frame_idx holds last shown frame
// ANIM_RUN  | sequence active, advancing on ticks
module anim_channel
  import anim_pkg::*;
#(
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int HOLD_W  = DEF_HOLD_W
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               tick,
  input  logic               load,
  input  logic               stop,
  input  logic [FRAME_W-1:0] ld_nframes,
  input  logic [HOLD_W-1:0]  ld_hold,
  input  logic               ld_loop,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_idx,
  output logic               done
);

  anim_state_t        state_q, state_d;
  logic [FRAME_W-1:0] nframes_q, nframes_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               loop_q, loop_d;
  logic               done_q, done_d;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ANIM_IDLE;
      nframes_q  <= '0;
      frame_q    <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nframes_q  <= nframes_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
      hold_cnt_q <= hold_cnt_d;
      loop_q     <= loop_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    nframes_d  = nframes_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    hold_cnt_d = hold_cnt_q;
    loop_d     = loop_q;
    done_d     = 1'b0;
    if (load) begin
      // zero counts are clamped to one so the terminal compares below never underflow
      state_d    = ANIM_RUN;
      nframes_d  = (ld_nframes == '0) ? FRAME_W'(1) : ld_nframes;
      hold_d     = (ld_hold == '0) ? HOLD_W'(1) : ld_hold;
      loop_d     = ld_loop & LOOP_EN;
      hold_cnt_d = '0;
      frame_d    = '0;
    end else if (state_q == ANIM_RUN) begin
      if (stop) begin
        state_d = ANIM_IDLE;
      end else if (tick) begin
        if (hold_cnt_q == hold_q - HOLD_W'(1)) begin
          hold_cnt_d = '0;
          if (frame_q == nframes_q - FRAME_W'(1)) begin
            if (loop_q) begin
              frame_d = '0;
            end else begin
              state_d = ANIM_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            frame_d = frame_q + FRAME_W'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
    end
  end

  assign busy      = (state_q == ANIM_RUN);
  assign frame_idx = frame_q;
  assign done      = done_q;

endmodule

// File: rtl/sprite_anim_scheduler.sv
// Multi-channel sprite animation scheduler: frame_clk synchronizer, round-robin load arbiter, channel array.
// Build with SPRITE_ANIM_LOOP_EN to honour req_loop; otherwise all sequences are one-shot.
module sprite_anim_scheduler
  import anim_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int FRAME_W = DEF_FRAME_W,
  parameter int HOLD_W  = DEF_HOLD_W
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      frame_clk,
  input  logic [NUM_CH-1:0]         req,
  input  logic [NUM_CH*FRAME_W-1:0] req_nframes,
  input  logic [NUM_CH*HOLD_W-1:0]  req_hold,
  input  logic [NUM_CH-1:0]         req_loop,
  input  logic [NUM_CH-1:0]         stop,
  output logic [NUM_CH-1:0]         gnt,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH*FRAME_W-1:0] frame_idx,
  output logic [NUM_CH-1:0]         done
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             fc_s1, fc_s2, fc_s3;
  logic             tick;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx, gnt_idx;
  logic [NUM_CH-1:0] eligible, gnt_c;
  logic             found;

  // Preset to 1 so a frame_clk already high at reset release is not seen as a rising edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_s1 <= 1'b1;
      fc_s2 <= 1'b1;
      fc_s3 <= 1'b1;
    end else begin
      fc_s1 <= frame_clk;
      fc_s2 <= fc_s1;
      fc_s3 <= fc_s2;
    end
  end

  assign tick     = fc_s2 & ~fc_s3;
  assign eligible = req & ~stop & ~busy;

  always_comb begin
    gnt_c   = '0;
    found   = 1'b0;
    idx     = '0;
    gnt_idx = ptr_q;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = PTR_W'((int'(ptr_q) + k) % NUM_CH);
      if (!found && eligible[idx]) begin
        found      = 1'b1;
        gnt_c[idx] = 1'b1;
        gnt_idx    = idx;
      end
    end
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign gnt = Reset ? '0 : gnt_c;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    anim_channel #(
      .FRAME_W (FRAME_W),
      .HOLD_W  (HOLD_W)
    ) u_ch (
      .Clk        (Clk),
      .Reset      (Reset),
      .tick       (tick),
      .load       (gnt[i]),
      .stop       (stop[i]),
      .ld_nframes (req_nframes[i*FRAME_W +: FRAME_W]),
      .ld_hold    (req_hold[i*HOLD_W +: HOLD_W]),
      .ld_loop    (req_loop[i]),
      .busy       (busy[i]),
      .frame_idx  (frame_idx[i*FRAME_W +: FRAME_W]),
      .done       (done[i])
    );
  end

endmodule

// File: tb/tb_sprite_anim_scheduler.sv
// Randomized scoreboard bench for sprite_anim_scheduler against a tick-count reference model.
// Honours SPRITE_ANIM_LOOP_EN the same way as the design build.
module tb_sprite_anim_scheduler;

  localparam int NUM_CH  = 4;
  localparam int FRAME_W = 4;
  localparam int HOLD_W  = 6;
  localparam int NCYC    = 4000;
  localparam int RST_AT  = 2000;
`ifdef SPRITE_ANIM_LOOP_EN
  localparam bit LOOP_ON = 1'b1;
`else
  localparam bit LOOP_ON = 1'b0;
`endif

  logic                      Clk;
  logic                      Reset;
  logic                      frame_clk;
  logic [NUM_CH-1:0]         req;
  logic [NUM_CH*FRAME_W-1:0] req_nframes;
  logic [NUM_CH*HOLD_W-1:0]  req_hold;
  logic [NUM_CH-1:0]         req_loop;
  logic [NUM_CH-1:0]         stop;
  logic [NUM_CH-1:0]         gnt;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH*FRAME_W-1:0] frame_idx;
  logic [NUM_CH-1:0]         done;

  sprite_anim_scheduler #(
    .NUM_CH  (NUM_CH),
    .FRAME_W (FRAME_W),
    .HOLD_W  (HOLD_W)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .req         (req),
    .req_nframes (req_nframes),
    .req_hold    (req_hold),
    .req_loop    (req_loop),
    .stop        (stop),
    .gnt         (gnt),
    .busy        (busy),
    .frame_idx   (frame_idx),
    .done        (done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int                        cyc;
    logic [NUM_CH-1:0]         gnt;
    logic [NUM_CH-1:0]         done;
    logic [NUM_CH-1:0]         busy;
    logic [NUM_CH*FRAME_W-1:0] fidx;
  } rec_t;

  rec_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: a channel is described by ticks elapsed since its grant.
  bit  m_run  [NUM_CH];
  bit  m_lp   [NUM_CH];
  int  m_n    [NUM_CH];
  int  m_h    [NUM_CH];
  int  m_t    [NUM_CH];
  int  m_frame[NUM_CH];
  logic [NUM_CH-1:0] m_done;
  int  m_ptr;
  bit  ms1, ms2, ms3;

  initial begin
    logic [NUM_CH-1:0]         g, g_prev, mbusy, mpb;
    logic [NUM_CH*FRAME_W-1:0] mfidx, mpf;
    bit   tick_now;
    int   ix, gi;
    rec_t r;
    frame_clk   = 1'b1;
    Reset       = 1'b1;
    req         = '0;
    req_nframes = '0;
    req_hold    = '0;
    req_loop    = '0;
    stop        = '0;
    g_prev      = '0;
    mpb         = '0;
    mpf         = '0;
    m_done      = '0;
    m_ptr       = 0;
    {ms1, ms2, ms3} = 3'b111;
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i] = 0; m_lp[i] = 0; m_n[i] = 1; m_h[i] = 1; m_t[i] = 0; m_frame[i] = 0;
    end

    for (int c = 1; c <= NCYC; c++) begin
      @(negedge Clk);
      cyc   = c;
      Reset = (c < 3) || (c >= RST_AT && c < RST_AT + 3);
      if (c >= RST_AT - 10 && c < RST_AT + 20) frame_clk = 1'b1;
      else if ($urandom_range(0, 5) == 0)      frame_clk = ~frame_clk;

      for (int i = 0; i < NUM_CH; i++) begin
        if (g_prev[i]) req[i] = 1'b0;
        if (!req[i] && c >= 4 && (c == 4 || $urandom_range(0, 15) == 0)) begin
          req[i] = 1'b1;
          req_nframes[i*FRAME_W +: FRAME_W] = FRAME_W'($urandom_range(0, 5));
          req_hold[i*HOLD_W +: HOLD_W]      = HOLD_W'($urandom_range(0, 3));
          req_loop[i]                       = 1'($urandom_range(0, 1));
        end
        stop[i] = (c > 4) && ($urandom_range(0, 63) == 0);
      end

      // round-robin search from the pointer over idle, unstopped requesters
      g  = '0;
      gi = -1;
      if (!Reset) begin
        for (int k = 0; k < NUM_CH; k++) begin
          ix = (m_ptr + k) % NUM_CH;
          if (gi < 0 && req[ix] && !stop[ix] && !m_run[ix]) begin
            gi    = ix;
            g[ix] = 1'b1;
          end
        end
      end

      for (int i = 0; i < NUM_CH; i++) begin
        mbusy[i] = m_run[i];
        mfidx[i*FRAME_W +: FRAME_W] = FRAME_W'(m_frame[i]);
      end
      if (c > 3 && (g != 0 || m_done != 0 || mbusy != mpb || mfidx != mpf)) begin
        r.cyc = c; r.gnt = g; r.done = m_done; r.busy = mbusy; r.fidx = mfidx;
        sb_q.push_back(r);
      end
      mpb = mbusy;
      mpf = mfidx;

      tick_now = ms2 && !ms3;
      if (Reset) begin
        {ms1, ms2, ms3} = 3'b111;
        m_ptr  = 0;
        m_done = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          m_run[i] = 0; m_t[i] = 0; m_frame[i] = 0;
        end
      end else begin
        ms3 = ms2; ms2 = ms1; ms1 = frame_clk;
        m_done = '0;
        for (int i = 0; i < NUM_CH; i++) begin
          if (g[i]) begin
            m_run[i]   = 1;
            m_n[i]     = (req_nframes[i*FRAME_W +: FRAME_W] == 0) ? 1 : int'(req_nframes[i*FRAME_W +: FRAME_W]);
            m_h[i]     = (req_hold[i*HOLD_W +: HOLD_W] == 0) ? 1 : int'(req_hold[i*HOLD_W +: HOLD_W]);
            m_lp[i]    = req_loop[i] && LOOP_ON;
            m_t[i]     = 0;
            m_frame[i] = 0;
          end else if (m_run[i]) begin
            if (stop[i]) begin
              m_run[i] = 0;
            end else if (tick_now) begin
              m_t[i]++;
              if (m_lp[i]) begin
                if (m_t[i] == m_n[i] * m_h[i]) m_t[i] = 0;
                m_frame[i] = (m_t[i] / m_h[i]) % m_n[i];
              end else begin
                m_frame[i] = (m_t[i] / m_h[i] > m_n[i] - 1) ? m_n[i] - 1 : m_t[i] / m_h[i];
                if (m_t[i] == m_n[i] * m_h[i]) begin
                  m_run[i]  = 0;
                  m_done[i] = 1'b1;
                end
              end
            end
          end
        end
        if (gi >= 0) m_ptr = (gi + 1) % NUM_CH;
      end
      g_prev = g;
    end

    repeat (2) @(negedge Clk);
    #2;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: pops an expectation whenever the DUT shows a grant, a done, or a change of busy/frame_idx.
  initial begin
    logic [NUM_CH-1:0]         pb;
    logic [NUM_CH*FRAME_W-1:0] pf;
    rec_t r;
    pb = '0;
    pf = '0;
    forever begin
      @(negedge Clk);
      #1;
      if (cyc == 3) begin
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_frame_idx", 64'(frame_idx), 64'd0);
        pb = busy;
        pf = frame_idx;
      end else if (cyc > 3) begin
        if (gnt != 0 || done != 0 || busy != pb || frame_idx != pf) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output at cycle %0d: gnt=%0h done=%0h busy=%0h frame_idx=%0h, expected no activity",
                     cyc, gnt, done, busy, frame_idx);
          end else begin
            r = sb_q.pop_front();
            chk("event_cycle", 64'(cyc), 64'(r.cyc));
            chk("gnt", 64'(gnt), 64'(r.gnt));
            chk("done", 64'(done), 64'(r.done));
            chk("busy", 64'(busy), 64'(r.busy));
            chk("frame_idx", 64'(frame_idx), 64'(r.fidx));
          end
        end
        pb = busy;
        pf = frame_idx;
      end
    end
  end

endmodule

// File: doc/sprite_anim_scheduler.md
SPRITE_ANIM_SCHEDULER -- requirements
Module: sprite_anim_scheduler

Interface
REQ-001 Parameter NUM_CH SHALL be: NUM_CH, 4, number of independent animation channels.
REQ-002 Parameter FRAME_W SHALL be: FRAME_W, 4, width of frame count and frame index.
REQ-003 Parameter HOLD_W SHALL be: HOLD_W, 6, width of per-frame hold count in frame ticks.
REQ-004 Port Clk SHALL be: Clk  input  1  system clock.
REQ-005 Port Reset SHALL be: Reset  input  1  reset, synchronous, active-high.
REQ-006 Port frame_clk SHALL be: frame_clk  input  1  ~60 Hz new-frame strobe, asynchronous to Clk.
REQ-007 Port req SHALL be: req  input  NUM_CH  per-channel start request, held until gnt.
REQ-008 Port req_nframes SHALL be: req_nframes  input  NUM_CH*FRAME_W  frames in sequence, channel i at [i*FRAME_W +: FRAME_W].
REQ-009 Port req_hold SHALL be: req_hold  input  NUM_CH*HOLD_W  ticks each frame is shown.
REQ-010 Port req_loop SHALL be: req_loop  input  NUM_CH  1 = wrap to frame 0 instead of finishing.
REQ-011 Port stop SHALL be: stop  input  NUM_CH  abort channel.
REQ-012 Port gnt SHALL be: gnt  output  NUM_CH  one-cycle load acknowledge, at most one bit set.
REQ-013 Port busy SHALL be: busy  output  NUM_CH  channel running.
REQ-014 Port frame_idx SHALL be: frame_idx  output  NUM_CH*FRAME_W  current frame index per channel.
REQ-015 Port done SHALL be: done  output  NUM_CH  one-cycle pulse on natural sequence end.

Function
REQ-016 frame_clk SHALL pass through a 2-flop synchronizer; internal tick SHALL be a one-Clk pulse when synchronized value is 1 and its delayed copy is 0.
REQ-017 Arbiter SHALL grant, round-robin, one channel per cycle among channels with req=1, stop=0 and not busy; search starts at pointer, pointer becomes granted index+1 (mod NUM_CH); no grant leaves pointer unchanged.
REQ-018 req from a busy channel SHALL be held pending, not dropped or granted.
REQ-019 On gnt[i] channel i SHALL capture nframes, hold, loop, set frame_idx=0, hold_cnt=0, state ANIM_RUN; busy[i]=1 from next cycle.
REQ-020 nframes=0 SHALL be treated as 1; hold=0 SHALL be treated as 1.
REQ-021 In ANIM_RUN on tick: hold_cnt==hold-1 -> hold_cnt=0 and frame advance; else hold_cnt+1.
REQ-022 Frame advance with frame_idx<nframes-1 SHALL increment frame_idx.
REQ-023 Frame advance at frame_idx==nframes-1: loop=1 -> frame_idx=0; loop=0 -> state ANIM_IDLE, busy=0 and done=1 next cycle, frame_idx holds last value.
REQ-024 stop[i] SHALL take priority over tick: next cycle ANIM_IDLE, busy=0, no done, frame_idx holds.
REQ-025 tick coinciding with gnt[i] SHALL be ignored by channel i.
REQ-026 Channels SHALL be independent; a done and a new gnt on the same channel SHALL be possible on consecutive cycles.

Reset
REQ-027 Reset SHALL clear gnt, busy, frame_idx, done, all hold_cnt, pointer to 0, states to ANIM_IDLE.
REQ-028 Reset SHALL load both synchronizer flops and the delayed copy with 1 so frame_clk high at release yields no tick.

Configuration
REQ-029 Macro SPRITE_ANIM_LOOP_EN defined: req_loop honored per REQ-023.
REQ-030 Macro SPRITE_ANIM_LOOP_EN undefined: req_loop port present but ignored; every sequence one-shot.

Structure
REQ-031 Package anim_pkg SHALL hold NUM_CH, FRAME_W, HOLD_W defaults and enum anim_state_t {ANIM_IDLE, ANIM_RUN}.
REQ-032 Per-channel FSM and counters SHALL be sub-module anim_channel, instantiated NUM_CH times; synchronizer and arbiter SHALL live in the top.

Verification
REQ-033 req[1], nframes=3, hold=2, loop=0, 8 ticks -> gnt[1] one cycle; frame_idx 0,0,1,1,2,2 per tick; done[1] after 6th tick; busy[1]=0.
REQ-034 req=4'b1111 same cycle, pointer 0 -> gnt order 0,1,2,3 on consecutive cycles, one-hot each.
REQ-035 Loop build, nframes=2, hold=1, loop=1, 5 ticks -> frame_idx 1,0,1,0,1, no done; without SPRITE_ANIM_LOOP_EN -> done after 2nd tick.
REQ-036 stop[2] same cycle as tick at frame_idx=1 -> busy[2]=0 next cycle, frame_idx[2]=1, done[2]=0.
REQ-037 Reset asserted mid-run with frame_clk held high, then released -> all outputs 0, no tick until frame_clk falls and rises again.
REQ-038 nframes=0, hold=0, loop=0 -> done after first tick, frame_idx=0.
